// File: rtl/pcie_ss_axis_arb_pkg.sv
// Shared types and helpers for the PCIe SS AXI-S TX arbiter.
package pcie_ss_axis_arb_pkg;

  localparam int unsigned MAX_CH   = 16;
  localparam int unsigned MAX_CH_W = 4;

  typedef enum logic {ARB_STRICT = 1'b0, ARB_RR = 1'b1} arb_mode_e;
  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} lock_state_e;

  typedef struct packed {
    logic                found;
    logic [MAX_CH_W-1:0] idx;
  } pick_t;

  // Rotating find-first: first set bit of req at or after ptr, wrapping at n.
  function automatic pick_t first_set_from(input logic [MAX_CH-1:0]   req,
                                           input logic [MAX_CH_W-1:0] ptr,
                                           input int unsigned         n);
    pick_t       res;
    int unsigned c;
    res = '0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      c = 32'(ptr) + i;
      if (c >= n) c = c - n;
      if (!res.found && (i < n) && req[c[MAX_CH_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = c[MAX_CH_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pcie_ss_arb_pick.sv
// Combinational winner pick: starved requesters first, then strict or rotating order.
module pcie_ss_arb_pick
  import pcie_ss_axis_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
) (
  input  arb_mode_e         mode,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] starved,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt_oh,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              gnt_vld
);

  pick_t starve_pick;
  pick_t order_pick;
  pick_t pick;

  // Starved requesters override the normal order; lowest index among them wins.
  always_comb begin
    starve_pick = first_set_from(MAX_CH'(req & starved), '0, NUM_CH);
    order_pick  = first_set_from(MAX_CH'(req),
                                 (mode == ARB_RR) ? MAX_CH_W'(ptr) : '0, NUM_CH);
    pick        = starve_pick.found ? starve_pick : order_pick;
    gnt_vld     = pick.found;
    gnt_idx     = CH_W'(pick.idx);
    gnt_oh      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      gnt_oh[i] = pick.found && (pick.idx == MAX_CH_W'(i));
    end
  end

endmodule

// File: rtl/pcie_ss_axis_tx_arb.sv
// Packet-atomic N-channel AXI-S TX arbiter with starvation promotion and registered output.
module pcie_ss_axis_tx_arb
  import pcie_ss_axis_arb_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned TDATA_W      = 512,
  parameter int unsigned TUSER_W      = 10,
  parameter int unsigned ARB_MODE     = 0,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             s_tvalid,
  output logic [NUM_CH-1:0]             s_tready,
  input  logic [NUM_CH-1:0]             s_tlast,
  input  logic [NUM_CH*TDATA_W-1:0]     s_tdata,
  input  logic [NUM_CH*TDATA_W/8-1:0]   s_tkeep,
  input  logic [NUM_CH*TUSER_W-1:0]     s_tuser_vendor,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic [TDATA_W-1:0]            m_tdata,
  output logic [TDATA_W/8-1:0]          m_tkeep,
  output logic [TUSER_W-1:0]            m_tuser_vendor,
  output logic                          o_busy,
  output logic [$clog2(NUM_CH)-1:0]     o_cur_ch
);

  localparam int unsigned CH_W   = $clog2(NUM_CH);
  localparam int unsigned KEEP_W = TDATA_W / 8;
  localparam int unsigned CNT_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  lock_state_e         state_q, state_d;
  logic [CH_W-1:0]     cur_ch_q;
  logic [CH_W-1:0]     rr_ptr_q;
  logic [CNT_W-1:0]    cnt_q [NUM_CH];
  logic [NUM_CH-1:0]   starved;
  logic [NUM_CH-1:0]   pick_oh;
  logic [CH_W-1:0]     pick_idx;
  logic                pick_vld;
  logic [CH_W-1:0]     sel_ch;
  logic                gnt_act;
  logic                load_c;
  logic                accept;
  logic                grant;

  logic [TDATA_W-1:0]  ch_data [NUM_CH];
  logic [KEEP_W-1:0]   ch_keep [NUM_CH];
  logic [TUSER_W-1:0]  ch_user [NUM_CH];

  // Unpack per-channel payload slices.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_data[i] = s_tdata[i*TDATA_W +: TDATA_W];
    assign ch_keep[i] = s_tkeep[i*KEEP_W +: KEEP_W];
    assign ch_user[i] = s_tuser_vendor[i*TUSER_W +: TUSER_W];
    assign starved[i] = (STARVE_LIMIT != 0) && (cnt_q[i] == CNT_W'(STARVE_LIMIT));

    a_hold_valid: assert property (@(posedge clk) disable iff (!rst_n)
      (s_tvalid[i] && !s_tready[i]) |=> s_tvalid[i]);
  end

  pcie_ss_arb_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .mode    ((ARB_MODE == 1) ? ARB_RR : ARB_STRICT),
    .req     (s_tvalid),
    .starved (starved),
    .ptr     (rr_ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  // Lock state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Lock next-state, channel select and per-channel ready.
  always_comb begin
    state_d  = state_q;
    sel_ch   = cur_ch_q;
    gnt_act  = 1'b1;
    s_tready = '0;
    load_c   = !m_tvalid || m_tready;
    if (state_q == IDLE) begin
      sel_ch  = pick_idx;
      gnt_act = pick_vld;
    end
    accept = gnt_act && s_tvalid[sel_ch] && load_c;
    grant  = accept && (state_q == IDLE);
    if (accept) begin
      if (state_q == IDLE && !s_tlast[sel_ch])     state_d = LOCK;
      else if (state_q == LOCK && s_tlast[sel_ch]) state_d = IDLE;
    end
    if (rst_n && gnt_act && load_c) s_tready[sel_ch] = 1'b1;
  end

  // Lock owner, rotating pointer and starvation counters update on packet grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ch_q <= '0;
      rr_ptr_q <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else if (grant) begin
      cur_ch_q <= sel_ch;
      rr_ptr_q <= (sel_ch == CH_W'(NUM_CH - 1)) ? '0 : sel_ch + CH_W'(1);
      for (int i = 0; i < NUM_CH; i++) begin
        if (pick_oh[i]) begin
          cnt_q[i] <= '0;
        end else if (s_tvalid[i] && (cnt_q[i] != CNT_W'(STARVE_LIMIT))) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // One-deep output register; holds while the sink stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid       <= 1'b0;
      m_tlast        <= 1'b0;
      m_tdata        <= '0;
      m_tkeep        <= '0;
      m_tuser_vendor <= '0;
    end else if (accept) begin
      m_tvalid       <= 1'b1;
      m_tlast        <= s_tlast[sel_ch];
      m_tdata        <= ch_data[sel_ch];
      m_tkeep        <= ch_keep[sel_ch];
      m_tuser_vendor <= ch_user[sel_ch];
    end else if (m_tready) begin
      m_tvalid       <= 1'b0;
    end
  end

  assign o_busy   = (state_q == LOCK);
  assign o_cur_ch = cur_ch_q;

endmodule

// File: tb/tb_pcie_ss_axis_tx_arb.sv
// Directed bench for pcie_ss_axis_tx_arb: strict (no starve), strict (starve=2) and round-robin instances.
module tb_pcie_ss_axis_tx_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  s_tvalid = '0;
  logic [3:0]  s_tlast = '0;
  logic [127:0] s_tdata = '0;
  logic [15:0] s_tkeep = '0;
  logic [39:0] s_tuser = '0;
  logic        m_tready = 1'b1;
  int          sel = 0;

  logic [3:0]  v_a    [3];
  logic [3:0]  rdy_a  [3];
  logic        mv_a   [3];
  logic        ml_a   [3];
  logic [31:0] md_a   [3];
  logic [3:0]  mk_a   [3];
  logic [9:0]  mu_a   [3];
  logic        busy_a [3];
  logic [1:0]  cc_a   [3];

  logic [3:0]  rdy;
  logic        mv, ml, busy;
  logic [31:0] md;
  logic [3:0]  mk;
  logic [9:0]  mu;
  logic [1:0]  cc;

  always #5 clk = ~clk;

  // Instance 0: strict, no promotion; 1: strict, STARVE_LIMIT=2; 2: round robin.
  for (genvar k = 0; k < 3; k++) begin : g_dut
    pcie_ss_axis_tx_arb #(
      .NUM_CH       (4),
      .TDATA_W      (32),
      .TUSER_W      (10),
      .ARB_MODE     ((k == 2) ? 1 : 0),
      .STARVE_LIMIT ((k == 1) ? 2 : 0)
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .s_tvalid       (v_a[k]),
      .s_tready       (rdy_a[k]),
      .s_tlast        (s_tlast),
      .s_tdata        (s_tdata),
      .s_tkeep        (s_tkeep),
      .s_tuser_vendor (s_tuser),
      .m_tvalid       (mv_a[k]),
      .m_tready       (m_tready),
      .m_tlast        (ml_a[k]),
      .m_tdata        (md_a[k]),
      .m_tkeep        (mk_a[k]),
      .m_tuser_vendor (mu_a[k]),
      .o_busy         (busy_a[k]),
      .o_cur_ch       (cc_a[k])
    );
  end

  always_comb begin
    for (int k = 0; k < 3; k++) v_a[k] = (sel == k) ? s_tvalid : 4'h0;
    rdy  = rdy_a[sel];
    mv   = mv_a[sel];
    ml   = ml_a[sel];
    md   = md_a[sel];
    mk   = mk_a[sel];
    mu   = mu_a[sel];
    busy = busy_a[sel];
    cc   = cc_a[sel];
  end

  int n_vec = 0;
  int n_err = 0;

  int src_pkts [4];
  int src_len  [4];
  int src_beat [4];
  int src_seq  [4];
  int exp_seq  [4];
  bit src_en   [4];
  bit src_on   [4];
  bit hs       [4];
  bit rdy_seen [4];
  bit rnd = 0;
  int rdy_mode = 0;
  int grants [$];
  int out_cnt = 0;
  bit pv = 0, prdy = 0, in_pkt = 0;
  logic [31:0] pdata = '0;
  int out_ch = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_state();
    for (int ch = 0; ch < 4; ch++) begin
      src_pkts[ch] = 0; src_len[ch] = 1; src_beat[ch] = 0; src_seq[ch] = 0;
      exp_seq[ch] = 0; src_en[ch] = 0; src_on[ch] = 0; hs[ch] = 0; rdy_seen[ch] = 0;
    end
    grants.delete();
    out_cnt = 0; pv = 0; prdy = 0; in_pkt = 0; rnd = 0; rdy_mode = 0;
    s_tvalid = '0;
    m_tready = 1'b1;
  endtask

  // Called at a falling edge; leaves reset released at a falling edge.
  task automatic do_reset(input int new_sel);
    rst_n = 1'b0;
    clear_state();
    sel = new_sel;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: advance sources on last handshakes, drive, sample at negedge+1.
  task automatic step();
    int c;
    for (int ch = 0; ch < 4; ch++) begin
      if (hs[ch]) begin
        src_seq[ch]++;
        src_beat[ch]++;
        if (src_beat[ch] == src_len[ch]) begin
          src_beat[ch] = 0;
          src_pkts[ch]--;
          src_on[ch] = 0;
        end
      end
      if (!src_on[ch] && src_en[ch] && src_pkts[ch] > 0 && (!rnd || $urandom_range(0, 2) == 0)) begin
        src_on[ch] = 1;
        if (rnd) src_len[ch] = int'($urandom_range(1, 4));
      end
      s_tvalid[ch] = src_on[ch];
      s_tlast[ch]  = (src_beat[ch] == src_len[ch] - 1);
      s_tdata[ch*32 +: 32] = {4'(ch), 4'(src_len[ch]), 4'(src_beat[ch]), 4'h0, 16'(src_seq[ch])};
      s_tkeep[ch*4 +: 4]   = 4'hF;
      s_tuser[ch*10 +: 10] = 10'(ch);
    end
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
    #1;
    for (int ch = 0; ch < 4; ch++) begin
      hs[ch] = s_tvalid[ch] && rdy[ch];
      if (rdy[ch]) rdy_seen[ch] = 1;
      if (hs[ch] && src_beat[ch] == 0) grants.push_back(ch);
    end
    if (pv && !prdy) begin
      chk("hold_valid", 32'(mv), 32'h1);
      chk("hold_data", md, pdata);
    end
    if (mv && m_tready) begin
      c = int'(md[29:28]);
      chk("ch_field", 32'(md[31:30]), 32'h0);
      chk("seq", 32'(md[15:0]), 32'(exp_seq[c] % 65536));
      chk("keep", 32'(mk), 32'hF);
      chk("tuser", 32'(mu), 32'(c));
      chk("tlast", 32'(ml), 32'(md[23:20] == 4'(md[27:24] - 4'd1)));
      if (in_pkt) chk("atomic", 32'(c), 32'(out_ch));
      exp_seq[c]++;
      out_ch = c;
      in_pkt = !ml;
      out_cnt++;
    end
    pv = mv; prdy = m_tready; pdata = md;
    @(negedge clk);
  endtask

  function automatic bit pending();
    bit p;
    p = mv;
    for (int ch = 0; ch < 4; ch++) p = p || (src_pkts[ch] > 0) || hs[ch];
    return p;
  endfunction

  // Run until every source is empty and the output register drained; then account beats.
  task automatic drain(input string tag);
    int n;
    n = 0;
    while (pending() && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) chk({tag, "_drain_timeout"}, 32'h1, 32'h0);
    for (int ch = 0; ch < 4; ch++) chk({tag, "_beats"}, 32'(exp_seq[ch]), 32'(src_seq[ch]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    clear_state();
    @(negedge clk);
    s_tvalid = 4'hF;
    #1;
    chk("rst_m_tvalid", 32'(mv), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cur_ch", 32'(cc), 32'h0);
    chk("rst_s_tready", 32'(rdy), 32'h0);
    @(negedge clk);
    do_reset(0);

    // T1 strict: ch0 streams 3-beat packets, ch2 waits.
    src_en[0] = 1; src_pkts[0] = 4; src_len[0] = 3;
    src_en[2] = 1; src_pkts[2] = 1; src_len[2] = 3;
    repeat (12) step();
    chk("t1_grants", 32'(grants.size()), 32'd4);
    foreach (grants[i]) chk("t1_grant_ch", 32'(grants[i]), 32'd0);
    chk("t1_out_beats", 32'(out_cnt), 32'd11);
    chk("t1_ch2_ready", 32'(rdy_seen[2]), 32'h0);
    drain("t1");

    // T2 round robin: four channels, single-beat packets.
    do_reset(2);
    for (int ch = 0; ch < 4; ch++) begin
      src_en[ch] = 1; src_pkts[ch] = 2; src_len[ch] = 1;
    end
    repeat (8) step();
    chk("t2_grants", 32'(grants.size()), 32'd8);
    foreach (grants[i]) chk("t2_order", 32'(grants[i]), 32'(i % 4));
    drain("t2");

    // T3 starvation promotion with limit 2.
    do_reset(1);
    src_en[0] = 1; src_pkts[0] = 6; src_len[0] = 1;
    src_en[3] = 1; src_pkts[3] = 2; src_len[3] = 1;
    repeat (6) step();
    chk("t3_grants", 32'(grants.size()), 32'd6);
    begin
      int exp_order [6] = '{0, 0, 3, 0, 0, 3};
      foreach (exp_order[i]) if (i < grants.size()) chk("t3_order", 32'(grants[i]), 32'(exp_order[i]));
    end
    drain("t3");

    // T4 atomicity under toggling backpressure.
    do_reset(0);
    rdy_mode = 1; m_tready = 1'b0;
    src_en[1] = 1; src_pkts[1] = 1; src_len[1] = 4;
    src_pkts[0] = 1; src_len[0] = 2;
    begin
      int n;
      n = 0;
      while (src_seq[1] < 2 && n < 50) begin step(); n++; end
    end
    chk("t4_busy", 32'(busy), 32'h1);
    chk("t4_cur_ch", 32'(cc), 32'd1);
    src_en[0] = 1;
    drain("t4");
    chk("t4_grants", 32'(grants.size()), 32'd2);
    if (grants.size() == 2) begin
      chk("t4_first", 32'(grants[0]), 32'd1);
      chk("t4_second", 32'(grants[1]), 32'd0);
    end

    // T5 reset in the middle of a 5-beat packet.
    do_reset(0);
    src_en[2] = 1; src_pkts[2] = 1; src_len[2] = 5;
    repeat (3) step();
    chk("t5_busy_pre", 32'(busy), 32'h1);
    chk("t5_cur_ch_pre", 32'(cc), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_m_tvalid", 32'(mv), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_s_tready", 32'(rdy), 32'h0);
    @(negedge clk);
    do_reset(0);
    src_en[3] = 1; src_pkts[3] = 1; src_len[3] = 1;
    src_en[0] = 1; src_pkts[0] = 1; src_len[0] = 1;
    drain("t5");
    chk("t5_grants", 32'(grants.size()), 32'd2);
    if (grants.size() == 2) chk("t5_first", 32'(grants[0]), 32'd0);

    // T6 random traffic on three channels, round robin then strict with promotion.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset((pass == 0) ? 2 : 1);
      rnd = 1; rdy_mode = 2;
      for (int ch = 0; ch < 3; ch++) begin
        src_en[ch] = 1; src_pkts[ch] = 12;
      end
      drain((pass == 0) ? "t6_rr" : "t6_sp");
      chk("t6_pkts", 32'(grants.size()), 32'd36);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
